// File: rtl/sensor_conditioner.sv
// sensor_conditioner: front-end for the reservoir level controller.
// Synchronises and debounces the three raw float-sensor lines. Only legal
// thermometer codes (000/001/011/111) reach s. An illegal code that persists
// is reported as a sensor fault, and s is forced to SAFE_CODE until the fault
// is cleared.
module sensor_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 4,      // stable cycles before a debounced bit changes (>=2)
    parameter int         FAULT_CYCLES    = 8,      // illegal cycles before FAULT (>=2)
    parameter logic [3:1] SAFE_CODE       = 3'b000  // s value driven while in FAULT
) (
    input  logic       clk,
    input  logic       reset,      // asynchronous, active-low
    input  logic [3:1] raw_s,
    input  logic       fault_clr,
    output logic [3:1] s,
    output logic       s_changed,
    output logic       fault,
    output logic       fault_lat
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int IW = $clog2(FAULT_CYCLES);

    typedef enum logic [1:0] {
        ST_TRACK = 2'd0,  // following the debounced code
        ST_HOLD  = 2'd1,  // illegal code seen, s frozen, counting
        ST_FAULT = 2'd2   // illegal code persisted, s forced safe
    } state_t;

    state_t          state;
    logic [3:1]      sy1;
    logic [3:1]      sy2;
    logic [3:1]      deb;
    logic [CW-1:0]   cnt [1:3];
    logic [IW-1:0]   inv_cnt;
    logic            code_legal;

    // Two-flop synchroniser on each raw sensor line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sy1 <= 3'b000;
            sy2 <= 3'b000;
        end else begin
            sy1 <= raw_s;
            sy2 <= sy1;
        end
    end

    // Per-bit debounce: a bit changes only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples. A sample that matches deb restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb <= 3'b000;
            for (int i = 1; i <= 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= 3; i++) begin
                if (sy2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i] <= sy2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Thermometer-code legality of the debounced code.
    assign code_legal = (deb == 3'b000) || (deb == 3'b001) ||
                        (deb == 3'b011) || (deb == 3'b111);

    // Level FSM: s, s_changed, fault and fault_lat are all registered here.
    // s moves on the same edge as the state transition that produces it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_TRACK;
            inv_cnt   <= '0;
            s         <= 3'b000;
            s_changed <= 1'b0;
            fault     <= 1'b0;
            fault_lat <= 1'b0;
        end else begin
            s_changed <= 1'b0;
            case (state)
                ST_TRACK: begin
                    if (!code_legal) begin
                        state     <= ST_HOLD;
                        inv_cnt   <= IW'(1);
                        fault     <= 1'b1;
                        fault_lat <= 1'b0;
                    end else begin
                        fault     <= 1'b0;
                        fault_lat <= 1'b0;
                        if (deb != s) begin
                            s         <= deb;
                            s_changed <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (code_legal) begin
                        state     <= ST_TRACK;
                        inv_cnt   <= '0;
                        s         <= deb;
                        s_changed <= (deb != s);
                        fault     <= 1'b0;
                        fault_lat <= 1'b0;
                    end else if (inv_cnt == IW'(FAULT_CYCLES - 1)) begin
                        state     <= ST_FAULT;
                        s         <= SAFE_CODE;
                        s_changed <= (SAFE_CODE != s);
                        fault     <= 1'b1;
                        fault_lat <= 1'b1;
                    end else begin
                        inv_cnt   <= inv_cnt + 1'b1;
                        fault     <= 1'b1;
                        fault_lat <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    // Leaving needs both an explicit clear and a legal code.
                    if (fault_clr && code_legal) begin
                        state     <= ST_TRACK;
                        inv_cnt   <= '0;
                        s         <= deb;
                        s_changed <= (deb != s);
                        fault     <= 1'b0;
                        fault_lat <= 1'b0;
                    end else begin
                        s         <= SAFE_CODE;
                        fault     <= 1'b1;
                        fault_lat <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_TRACK;
                    inv_cnt   <= '0;
                    s         <= 3'b000;
                    s_changed <= (s != 3'b000);
                    fault     <= 1'b0;
                    fault_lat <= 1'b0;
                end
            endcase
        end
    end

endmodule
